// File: rtl/dnn_stream_host.sv
// dnn_stream_host: host-side stream endpoint for the accelerator.
// The source channel reads a local RAM and streams it out on src_*.
// The result channel accepts dst_* beats and writes them into a result RAM.
// One start pulse launches both channels. done pulses once when both have finished.
module dnn_stream_host #(
   parameter int AW = 12,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] src_len,
   input  logic [AW-1:0] dst_len,
   output logic          busy,
   output logic          done,
   output logic          err_last,
   output logic          sm_re,
   output logic [AW-1:0] sm_ra,
   input  logic [DW-1:0] sm_rd,
   output logic          rm_we,
   output logic [AW-1:0] rm_wa,
   output logic [DW-1:0] rm_wd,
   output logic          src_valid,
   output logic [DW-1:0] src_data,
   output logic          src_last,
   input  logic          src_ready,
   input  logic          dst_valid,
   input  logic [DW-1:0] dst_data,
   input  logic          dst_last,
   output logic          dst_ready
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;
   localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

   // Counters are one bit wider than the addresses, so a full 2^AW transfer ends cleanly.
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [0:0]    src_st_q, src_st_d;
   logic [0:0]    dst_st_q, dst_st_d;
   logic [AW:0]   src_len_q, src_len_d;
   logic [AW:0]   dst_len_q, dst_len_d;
   logic [AW:0]   rp_q, rp_d;
   logic [AW:0]   sc_q, sc_d;
   logic [AW:0]   wc_q, wc_d;
   logic [DW-1:0] fifo_q [2];
   logic [DW-1:0] fifo_d [2];
   logic          head_q, head_d;
   logic [1:0]    cnt_q, cnt_d;
   logic          infl_q, infl_d;

   logic          accept;
   logic          src_xfer;
   logic          dst_acc;
   logic          wr_idx;
   logic          src_done_now;
   logic          dst_done_now;

   // Datapath decode. The word returning from the RAM is visible at the FIFO head in
   // the cycle it lands (bypass). That gives the first beat 2 cycles after start and
   // sustains 1 beat per cycle.
   always_comb begin
      accept       = start & ~busy_q;
      sm_re        = (src_st_q == ST_RUN) && (rp_q <= src_len_q) &&
                     (({1'b0, cnt_q} + {2'b00, infl_q}) < 3'd2);
      sm_ra        = rp_q[AW-1:0];
      src_valid    = (cnt_q != 2'd0) | infl_q;
      src_data     = (cnt_q != 2'd0) ? fifo_q[head_q] : (infl_q ? sm_rd : '0);
      src_last     = src_valid && (sc_q == src_len_q);
      src_xfer     = src_valid & src_ready;
      dst_ready    = (dst_st_q == ST_RUN) && (wc_q <= dst_len_q);
      dst_acc      = dst_valid & dst_ready;
      rm_we        = dst_acc;
      rm_wa        = dst_acc ? wc_q[AW-1:0] : '0;
      rm_wd        = dst_acc ? dst_data : '0;
      wr_idx       = head_q ^ cnt_q[0];
      src_done_now = src_xfer & src_last;
      dst_done_now = dst_acc && (wc_q == dst_len_q);
   end

   // Next-state logic for both channels, the start/done handshake and the error flag.
   always_comb begin
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = err_q;
      src_st_d  = src_st_q;
      dst_st_d  = dst_st_q;
      src_len_d = src_len_q;
      dst_len_d = dst_len_q;
      rp_d      = rp_q;
      sc_d      = sc_q;
      wc_d      = wc_q;
      fifo_d    = fifo_q;
      head_d    = head_q;
      cnt_d     = cnt_q;
      infl_d    = 1'b0;

      if (accept) begin
         busy_d    = 1'b1;
         err_d     = 1'b0;
         src_st_d  = ST_RUN;
         dst_st_d  = ST_RUN;
         src_len_d = {1'b0, src_len};
         dst_len_d = {1'b0, dst_len};
         rp_d      = '0;
         sc_d      = '0;
         wc_d      = '0;
         head_d    = 1'b0;
         cnt_d     = 2'd0;
      end else begin
         // Source: issue a read, land the previous read, pop on transfer.
         infl_d = sm_re;
         if (sm_re) begin
            rp_d = rp_q + CNT_ONE;
         end
         // A landing word goes straight out when the FIFO is empty and the beat transfers.
         if (infl_q && !(src_xfer && (cnt_q == 2'd0))) begin
            fifo_d[wr_idx] = sm_rd;
         end
         case ({infl_q, src_xfer})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
         endcase
         if (src_xfer && (cnt_q != 2'd0)) begin
            head_d = ~head_q;
         end
         if (src_xfer) begin
            sc_d = sc_q + CNT_ONE;
         end
         if (src_done_now) begin
            src_st_d = ST_IDLE;
         end

         // Result: count beats. The length alone decides the end; dst_last is only checked.
         if (dst_acc) begin
            wc_d = wc_q + CNT_ONE;
            if (dst_last != (wc_q == dst_len_q)) begin
               err_d = 1'b1;
            end
         end
         if (dst_done_now) begin
            dst_st_d = ST_IDLE;
         end

         // A single done pulse follows the cycle in which the last running channel finishes.
         done_d = busy_q && ((src_st_q == ST_RUN) || (dst_st_q == ST_RUN)) &&
                  (src_st_d == ST_IDLE) && (dst_st_d == ST_IDLE);
         busy_d = busy_q & ~done_d;
      end
   end

   // Control and counter registers. Reset aborts any transfer immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         src_st_q  <= ST_IDLE;
         dst_st_q  <= ST_IDLE;
         src_len_q <= '0;
         dst_len_q <= '0;
         rp_q      <= '0;
         sc_q      <= '0;
         wc_q      <= '0;
         head_q    <= 1'b0;
         cnt_q     <= 2'd0;
         infl_q    <= 1'b0;
      end else begin
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         src_st_q  <= src_st_d;
         dst_st_q  <= dst_st_d;
         src_len_q <= src_len_d;
         dst_len_q <= dst_len_d;
         rp_q      <= rp_d;
         sc_q      <= sc_d;
         wc_q      <= wc_d;
         head_q    <= head_d;
         cnt_q     <= cnt_d;
         infl_q    <= infl_d;
      end
   end

   // Two-entry source holding FIFO storage.
   for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      // Entry register.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            fifo_q[gi] <= '0;
         end else begin
            fifo_q[gi] <= fifo_d[gi];
         end
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign err_last = err_q;

endmodule

// File: doc/dnn_stream_host.md
Name: dnn_stream_host

Overview:
- Host-side stream endpoint for the accelerator's sample streams.
- Transmits the src stream: it reads words from a local source RAM and drives src_valid/src_data/src_last into the accelerator.
- Receives the dst stream: it accepts dst_valid/dst_data/dst_last and writes each beat into a local result RAM.
- Both channels start on one start pulse and run concurrently. done pulses when both finish. Sits between the test/host memory subsystem and the accelerator top.

Parameters:
AW, 12, word-address width of both RAM ports and both length inputs
DW, 32, stream and RAM data width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a transfer when idle
src_len  in  AW  source words minus one (0 = one word)
dst_len  in  AW  result words minus one
busy  out  1  transfer in progress
done  out  1  one-cycle pulse when both channels complete
err_last  out  1  sticky; dst_last disagreed with dst_len; cleared by accepted start
sm_re  out  1  source RAM read enable
sm_ra  out  AW  source RAM read address
sm_rd  in  DW  source RAM read data; valid exactly 1 cycle after sm_re
rm_we  out  1  result RAM write enable
rm_wa  out  AW  result RAM write address
rm_wd  out  DW  result RAM write data
src_valid  out  1  stream beat valid
src_data  out  DW  stream beat data
src_last  out  1  final source beat
src_ready  in  1  accelerator accepts beat
dst_valid  in  1  result beat valid
dst_data  in  DW  result beat data
dst_last  in  1  final result beat
dst_ready  out  1  this block accepts beat

Behaviour:
- Reset: every output and internal register goes to 0, and both channels go to IDLE. Reset asserted mid-transfer aborts immediately: no further RAM accesses and no done pulse.
- Start handling:
  - start is accepted only when busy=0. start while busy is ignored.
  - On acceptance, src_len and dst_len are latched, err_last is cleared, busy=1 from the next cycle, and both channels enter RUN.
- Source channel:
  - Read pointer rp and send counter sc both start at 0.
  - Holding storage is a 2-entry FIFO.
  - A read is issued (sm_re=1, sm_ra=rp, rp++) when rp<=src_len_latched and FIFO occupancy plus reads in flight is less than 2.
  - sm_rd is pushed into the FIFO on the following cycle.
  - src_valid = FIFO not empty. src_data = FIFO head. src_last = (sc==src_len_latched) while src_valid.
  - A beat transfers when src_valid & src_ready; that pops the FIFO and increments sc.
  - Steady state with src_ready held high is 1 beat per cycle. The first src_valid appears 2 cycles after the accepted start.
  - src_valid, once high, stays high until the beat transfers. src_data is stable while src_valid & !src_ready.
  - The channel is complete after the transfer with src_last=1. It then returns to IDLE and issues no more reads.
- Result channel:
  - Write counter wc starts at 0.
  - dst_ready=1 while in RUN and wc<=dst_len_latched; otherwise 0.
  - Each accepted beat (dst_valid & dst_ready) produces, in the same cycle, rm_we=1, rm_wa=wc, rm_wd=dst_data. wc increments.
  - If dst_last differs from (wc==dst_len_latched) on an accepted beat, err_last is set.
  - The channel completes on the beat where wc==dst_len_latched, regardless of dst_last. Beats offered after completion are not accepted (dst_ready=0).
- Completion:
  - done pulses for 1 cycle, and busy falls in that same cycle, in the cycle after both channels are complete.
  - Either channel may finish first. Simultaneous completion still gives exactly one done pulse.
  - A start in the done cycle is accepted, since busy is already 0 there.
- Width and wrap:
  - Counters are AW+1 bits internally, so src_len = 2^AW-1 terminates without wrap.
  - Addresses are counter[AW-1:0].

Test Plan:
- Source, no backpressure:
  - Stimulus: source RAM words 0..3 = 0x11,0x22,0x33,0x44; src_len=3; src_ready=1.
  - Required: beats on 4 consecutive cycles starting 2 cycles after start; src_last only on 0x44; exactly 4 sm_re pulses.
- Source, backpressure:
  - Stimulus: same data; src_ready alternates 1,0.
  - Required: each word held stable while stalled, no word duplicated or dropped, FIFO never exceeds 2.
- Result, normal:
  - Stimulus: dst_len=2; beats 0xA0,0xA1,0xA2 with dst_last on the third.
  - Required: rm_wa 0,1,2 with matching data; err_last=0; dst_ready drops after the third beat; a fourth offered beat is not written.
- Result, early last:
  - Stimulus: dst_len=2; dst_last asserted on the second beat.
  - Required: err_last=1; the third beat is still accepted and written to address 2; done still pulses.
- Concurrency and start rules:
  - Stimulus: src_len=0 and dst_len=5; result beats arrive late.
  - Required: the source completes first; done pulses once, one cycle after the 6th result beat. A start issued mid-transfer is ignored. Reset asserted mid-transfer forces busy, src_valid and dst_ready to 0 and no done pulse follows.
